axi_lite_slice: RTL

// - Parametrised, registered AXI-Lite master-side slice between core m_axi_lite (s_* side) and the SoC interconnect (m_* side), on flat ports.
// - Every channel (AW, W, B, AR, R) is buffered by a 2-entry skid buffer: full throughput, no combinational valid/ready path across the block.
// - Read and write outstanding transactions are each capped at MAX_OUTSTANDING; optional per-direction statistics for debug.
//

---
 rtl/axi_lite_slice.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_slice.sv
// -----------------------------------------------------------------------------
// axi_lite_slice
//
// Registered AXI-Lite master-side slice. It sits between a core's AXI-Lite
// master (s_axi_lite_* side) and the SoC interconnect (m_axi_lite_* side).
// Each of the five channels passes through a 2-entry skid buffer. The buffer
// gives full throughput and has no combinational valid->ready path across the
// block. Read and write transactions in flight are each capped at
// MAX_OUTSTANDING.
//
// Optional feature macro: AXI_LITE_SLICE_STATS_EN
//   defined   -> stat_wr_done / stat_rd_done / stat_err are saturating
//                32-bit counters of upstream B/R handshakes and error
//                responses.
//   undefined -> stat_* ports are tied to 0 and no counters are built.
//
// Ports
//   aclk, aresetn                 clock, async active-low reset
//   s_axi_lite_aw*/w*/ar*         upstream requests in (valid/payload in,
//                                 ready out)
//   s_axi_lite_b*/r*              upstream responses out (valid/payload out,
//                                 ready in)
//   m_axi_lite_*                  downstream mirror of s_*, directions inverted
//   wr_outstanding                accepted AW minus delivered B
//   rd_outstanding                accepted AR minus delivered R
//   stat_wr_done, stat_rd_done    completed write / read count
//   stat_err                      responses with resp != OKAY
//
// DATA_WIDTH must be 32 or 64. STRB_WIDTH is derived and is not overridden.
// -----------------------------------------------------------------------------

// Two-entry skid buffer: a main (output) register plus one skid register.
// in_ready comes only from the registered skid-full flag.
module axi_lite_slice_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             skid_vld_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic             in_hs;
  logic             main_free;

  assign in_ready  = !skid_vld_p1;
  assign in_hs     = in_valid && !skid_vld_p1;
  // The main register can take a new beat when it is empty or draining now.
  assign main_free = !vld_p1 || out_ready;

  // ---- stage p1: control (valid flags) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (main_free) begin
      vld_p1      <= skid_vld_p1 || in_hs;
      skid_vld_p1 <= 1'b0;
    end else if (in_hs) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // ---- stage p1: payload (no reset, qualified by the valid flags) ----
  // The skid entry always wins over a new beat. A new beat cannot arrive
  // while the skid is full, because in_ready is low then.
  always_ff @(posedge clk) begin
    if (main_free) begin
      if (skid_vld_p1) begin
        data_p1 <= skid_data_p1;
      end else if (in_hs) begin
        data_p1 <= in_data;
      end
    end else if (in_hs) begin
      skid_data_p1 <= in_data;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

module axi_lite_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // upstream (core master)
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_lite_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [DATA_WIDTH-1:0] s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready,
  // downstream (interconnect)
  output logic [ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                  m_axi_lite_awvalid,
  input  logic                  m_axi_lite_awready,
  output logic [DATA_WIDTH-1:0] m_axi_lite_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_lite_wstrb,
  output logic                  m_axi_lite_wvalid,
  input  logic                  m_axi_lite_wready,
  input  logic [1:0]            m_axi_lite_bresp,
  input  logic                  m_axi_lite_bvalid,
  output logic                  m_axi_lite_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                  m_axi_lite_arvalid,
  input  logic                  m_axi_lite_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_lite_rdata,
  input  logic [1:0]            m_axi_lite_rresp,
  input  logic                  m_axi_lite_rvalid,
  output logic                  m_axi_lite_rready,
  // status
  output logic [3:0]            wr_outstanding,
  output logic [3:0]            rd_outstanding,
  output logic [31:0]           stat_wr_done,
  output logic [31:0]           stat_rd_done,
  output logic [31:0]           stat_err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0] wr_cnt_q;
  logic [3:0] rd_cnt_q;
  logic       aw_cap_ok, ar_cap_ok;
  logic       aw_in_ready, ar_in_ready;
  logic       aw_hs, b_hs, ar_hs, r_hs;

  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_out;
  logic [DATA_WIDTH+1:0]            r_out;

  // Outstanding-count update. A response with nothing outstanding is a
  // downstream protocol error. The count holds at 0 instead of wrapping.
  function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 4'd1;
    end else if (!inc && dec) begin
      res = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    end else if (inc && dec && cnt == 4'd0) begin
      res = 4'd1;
    end
    return res;
  endfunction

  assign aw_cap_ok = (wr_cnt_q < MAX_CNT);
  assign ar_cap_ok = (rd_cnt_q < MAX_CNT);

  assign s_axi_lite_awready = aw_in_ready && aw_cap_ok;
  assign s_axi_lite_arready = ar_in_ready && ar_cap_ok;

  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;
  assign b_hs  = s_axi_lite_bvalid  && s_axi_lite_bready;
  assign r_hs  = s_axi_lite_rvalid  && s_axi_lite_rready;

  axi_lite_slice_skid #(.WIDTH(ADDR_WIDTH)) u_aw (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(s_axi_lite_awvalid && aw_cap_ok), .in_ready(aw_in_ready),
    .in_data(s_axi_lite_awaddr),
    .out_valid(m_axi_lite_awvalid), .out_ready(m_axi_lite_awready),
    .out_data(m_axi_lite_awaddr)
  );

  axi_lite_slice_skid #(.WIDTH(DATA_WIDTH+STRB_WIDTH)) u_w (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(s_axi_lite_wvalid), .in_ready(s_axi_lite_wready),
    .in_data({s_axi_lite_wdata, s_axi_lite_wstrb}),
    .out_valid(m_axi_lite_wvalid), .out_ready(m_axi_lite_wready),
    .out_data(w_out)
  );
  assign {m_axi_lite_wdata, m_axi_lite_wstrb} = w_out;

  axi_lite_slice_skid #(.WIDTH(2)) u_b (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(m_axi_lite_bvalid), .in_ready(m_axi_lite_bready),
    .in_data(m_axi_lite_bresp),
    .out_valid(s_axi_lite_bvalid), .out_ready(s_axi_lite_bready),
    .out_data(s_axi_lite_bresp)
  );

  axi_lite_slice_skid #(.WIDTH(ADDR_WIDTH)) u_ar (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(s_axi_lite_arvalid && ar_cap_ok), .in_ready(ar_in_ready),
    .in_data(s_axi_lite_araddr),
    .out_valid(m_axi_lite_arvalid), .out_ready(m_axi_lite_arready),
    .out_data(m_axi_lite_araddr)
  );

  axi_lite_slice_skid #(.WIDTH(DATA_WIDTH+2)) u_r (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(m_axi_lite_rvalid), .in_ready(m_axi_lite_rready),
    .in_data({m_axi_lite_rdata, m_axi_lite_rresp}),
    .out_valid(s_axi_lite_rvalid), .out_ready(s_axi_lite_rready),
    .out_data(r_out)
  );
  assign {s_axi_lite_rdata, s_axi_lite_rresp} = r_out;

  // ---- outstanding counters ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
    end else begin
      wr_cnt_q <= next_count(wr_cnt_q, aw_hs, b_hs);
      rd_cnt_q <= next_count(rd_cnt_q, ar_hs, r_hs);
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;

  // A response delivered upstream with nothing outstanding means the
  // interconnect returned an unsolicited B/R.
  assert property (@(posedge aclk) disable iff (!aresetn)
                   b_hs |-> (wr_cnt_q != 4'd0));
  assert property (@(posedge aclk) disable iff (!aresetn)
                   r_hs |-> (rd_cnt_q != 4'd0));

`ifdef AXI_LITE_SLICE_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q, stat_err_q;
  logic [1:0]  err_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [1:0]  n);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'd0, n};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // A B error and an R error in the same cycle count as two.
  assign err_inc = {1'b0, b_hs && (s_axi_lite_bresp != 2'b00)} +
                   {1'b0, r_hs && (s_axi_lite_rresp != 2'b00)};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_wr_q  <= 32'd0;
      stat_rd_q  <= 32'd0;
      stat_err_q <= 32'd0;
    end else begin
      stat_wr_q  <= sat_add(stat_wr_q, {1'b0, b_hs});
      stat_rd_q  <= sat_add(stat_rd_q, {1'b0, r_hs});
      stat_err_q <= sat_add(stat_err_q, err_inc);
    end
  end

  assign stat_wr_done = stat_wr_q;
  assign stat_rd_done = stat_rd_q;
  assign stat_err     = stat_err_q;
`else
  assign stat_wr_done = 32'd0;
  assign stat_rd_done = 32'd0;
  assign stat_err     = 32'd0;
`endif

endmodule
